// File: rtl/cache_fill_ctrl_pkg.sv
// rtl/cache_fill_ctrl_pkg.sv - shared parameters, state encoding and PLRU helpers for the cache fill controller
package cache_fill_ctrl_pkg;

    localparam int SETS       = 4;
    localparam int WAYS       = 4;
    localparam int TAG_W      = 8;
    localparam int DATA_W     = 32;
    localparam int LINE_BEATS = 4;
    localparam int IDX_W      = $clog2(SETS);
    localparam int BEAT_W     = $clog2(LINE_BEATS);
    localparam int WAY_W      = $clog2(WAYS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2,
        ST_TAGW = 2'd3
    } fill_state_e;

    // bit 0 = root (b0), bit 1 = left pair (b1), bit 2 = right pair (b2)
    typedef logic [2:0] plru_t;

    function automatic logic [WAY_W-1:0] plru_victim(input plru_t p);
        if (!p[0]) begin
            return p[1] ? 2'd1 : 2'd0;
        end
        return p[2] ? 2'd3 : 2'd2;
    endfunction

    function automatic plru_t plru_update(input plru_t p, input logic [WAY_W-1:0] way);
        plru_t n;
        n = p;
        if (!way[1]) begin
            n[0] = 1'b1;
            n[1] = (way == 2'd0);
        end else begin
            n[0] = 1'b0;
            n[2] = (way == 2'd2);
        end
        return n;
    endfunction

    function automatic logic [WAYS-1:0] way_onehot(input logic [WAY_W-1:0] way);
        return 4'b0001 << way;
    endfunction

    function automatic logic [WAY_W-1:0] first_way(input logic [WAYS-1:0] mask);
        logic [WAY_W-1:0] r;
        r = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (mask[i]) r = 2'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// rtl/cache_fill_ctrl_if.sv - lookup, memory request/response and array write bundle of the fill controller
interface cache_fill_ctrl_if;
    import cache_fill_ctrl_pkg::*;

    logic                  lookup_valid;
    logic [IDX_W-1:0]      lookup_index;
    logic [TAG_W-1:0]      lookup_tag;
    logic [WAYS-1:0]       hit_raw;
    logic                  flush;
    logic [WAYS-1:0]       hit_q;
    logic                  miss_stall;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [TAG_W+IDX_W-1:0] mem_req_addr;
    logic                  mem_rsp_valid;
    logic [DATA_W-1:0]     mem_rsp_data;
    logic                  data_wr_en;
    logic [WAYS-1:0]       data_wr_way;
    logic [IDX_W-1:0]      data_wr_index;
    logic [BEAT_W-1:0]     data_wr_beat;
    logic [DATA_W-1:0]     data_wr_data;
    logic                  tag_wr_en;
    logic [WAYS-1:0]       tag_wr_way;
    logic [IDX_W-1:0]      tag_wr_index;
    logic [TAG_W-1:0]      tag_wr_tag;
    logic                  fill_done;

    modport master (
        input  lookup_valid, lookup_index, lookup_tag, hit_raw, flush,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output hit_q, miss_stall, mem_req_valid, mem_req_addr,
        output data_wr_en, data_wr_way, data_wr_index, data_wr_beat, data_wr_data,
        output tag_wr_en, tag_wr_way, tag_wr_index, tag_wr_tag, fill_done
    );

    modport slave (
        output lookup_valid, lookup_index, lookup_tag, hit_raw, flush,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  hit_q, miss_stall, mem_req_valid, mem_req_addr,
        input  data_wr_en, data_wr_way, data_wr_index, data_wr_beat, data_wr_data,
        input  tag_wr_en, tag_wr_way, tag_wr_index, tag_wr_tag, fill_done
    );

endinterface

// File: rtl/cache_fill_ctrl_plru.sv
// rtl/cache_fill_ctrl_plru.sv - 4-way tree pseudo-LRU: victim of a set and its state after an access
import cache_fill_ctrl_pkg::*;

module plru_tree4 (
    input  plru_t            state,
    input  logic [WAY_W-1:0] access_way,
    output logic [WAY_W-1:0] victim,
    output plru_t            next_state
);

    assign victim     = plru_victim(state);
    assign next_state = plru_update(state, access_way);

endmodule

// File: rtl/cache_fill_ctrl.sv
// rtl/cache_fill_ctrl.sv - miss/fill controller: hit qualification, PLRU victim choice, line fill, tag-last install
import cache_fill_ctrl_pkg::*;

module cache_fill_ctrl (
    input  logic             clk,
    input  logic             rst,
    cache_fill_ctrl_if.master bus
);

    fill_state_e       state;
    logic [WAYS-1:0]   valid [SETS];
    plru_t             plru  [SETS];
    logic [BEAT_W-1:0] beat_cnt;
    logic [IDX_W-1:0]  fill_index;
    logic [TAG_W-1:0]  fill_tag;
    logic [WAY_W-1:0]  fill_way;
    logic              req_valid_q;
    logic              tag_wr_q;

    logic              idle;
    logic [WAYS-1:0]   set_valid;
    logic              hit_any;
    logic              miss;
    logic              beat_take;
    plru_t             plru_cur;
    plru_t             plru_next;
    logic [WAY_W-1:0]  access_way;
    logic [WAY_W-1:0]  lru_way;
    logic [WAY_W-1:0]  victim_way;

    assign idle      = (state == ST_IDLE);
    assign set_valid = valid[bus.lookup_index];
    assign hit_any   = |bus.hit_q;
    assign miss      = idle & bus.lookup_valid & ~bus.flush & ~hit_any;
    assign beat_take = (state == ST_FILL) & bus.mem_rsp_valid;

    // One tree serves both the IDLE lookup set and the set being installed in TAGW.
    assign plru_cur   = idle ? plru[bus.lookup_index] : plru[fill_index];
    assign access_way = idle ? first_way(bus.hit_q) : fill_way;

    plru_tree4 u_plru (
        .state      (plru_cur),
        .access_way (access_way),
        .victim     (lru_way),
        .next_state (plru_next)
    );

    assign victim_way = (&set_valid) ? lru_way : first_way(~set_valid);

    assign bus.hit_q         = bus.hit_raw & set_valid;
    assign bus.miss_stall    = miss | ~idle;
    assign bus.mem_req_valid = req_valid_q;
    assign bus.mem_req_addr  = req_valid_q ? {fill_tag, fill_index} : '0;
    assign bus.data_wr_en    = beat_take;
    assign bus.data_wr_way   = beat_take ? way_onehot(fill_way) : '0;
    assign bus.data_wr_index = beat_take ? fill_index : '0;
    assign bus.data_wr_beat  = beat_take ? beat_cnt : '0;
    assign bus.data_wr_data  = bus.mem_rsp_data;
    assign bus.tag_wr_en     = tag_wr_q;
    assign bus.tag_wr_way    = tag_wr_q ? way_onehot(fill_way) : '0;
    assign bus.tag_wr_index  = tag_wr_q ? fill_index : '0;
    assign bus.tag_wr_tag    = tag_wr_q ? fill_tag : '0;
    assign bus.fill_done     = tag_wr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            beat_cnt    <= '0;
            fill_index  <= '0;
            fill_tag    <= '0;
            fill_way    <= '0;
            req_valid_q <= 1'b0;
            tag_wr_q    <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                plru[s]  <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.flush) begin
                        for (int s = 0; s < SETS; s++) begin
                            valid[s] <= '0;
                            plru[s]  <= '0;
                        end
                    end else if (bus.lookup_valid && hit_any) begin
                        plru[bus.lookup_index] <= plru_next;
                    end else if (miss) begin
                        fill_index  <= bus.lookup_index;
                        fill_tag    <= bus.lookup_tag;
                        fill_way    <= victim_way;
                        // stale contents of the victim must not hit while it is refilled
                        valid[bus.lookup_index][victim_way] <= 1'b0;
                        req_valid_q <= 1'b1;
                        state       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        beat_cnt    <= '0;
                        state       <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (bus.mem_rsp_valid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == BEAT_W'(LINE_BEATS - 1)) begin
                            tag_wr_q <= 1'b1;
                            state    <= ST_TAGW;
                        end
                    end
                end
                ST_TAGW: begin
                    valid[fill_index][fill_way] <= 1'b1;
                    plru[fill_index]            <= plru_next;
                    tag_wr_q                    <= 1'b0;
                    state                       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb/tb_cache_fill_ctrl.sv - scoreboard bench for cache_fill_ctrl
module tb_cache_fill_ctrl;
    import cache_fill_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_fill_ctrl_if bus();

    cache_fill_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [39:0] data_q [$];
    logic [13:0] tag_q  [$];
    logic [39:0] dexp;
    logic [13:0] texp;

    logic [3:0] m_valid [4];
    logic [2:0] m_plru  [4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] oh(input logic [1:0] w);
        case (w)
            2'd0: return 4'b0001;
            2'd1: return 4'b0010;
            2'd2: return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [1:0] lowest(input logic [3:0] m);
        if (m[0]) return 2'd0;
        if (m[1]) return 2'd1;
        if (m[2]) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [1:0] m_victim(input logic [1:0] s);
        logic [2:0] b;
        if (m_valid[s] != 4'b1111) return lowest(~m_valid[s]);
        b = m_plru[s];
        case ({b[0], b[1], b[2]})
            3'b000, 3'b001: return 2'd0;
            3'b010, 3'b011: return 2'd1;
            3'b100, 3'b110: return 2'd2;
            default:        return 2'd3;
        endcase
    endfunction

    function automatic void m_touch(input logic [1:0] s, input logic [1:0] w);
        case (w)
            2'd0: begin m_plru[s][0] = 1'b1; m_plru[s][1] = 1'b1; end
            2'd1: begin m_plru[s][0] = 1'b1; m_plru[s][1] = 1'b0; end
            2'd2: begin m_plru[s][0] = 1'b0; m_plru[s][2] = 1'b1; end
            default: begin m_plru[s][0] = 1'b0; m_plru[s][2] = 1'b0; end
        endcase
    endfunction

    function automatic void m_clear();
        for (int s = 0; s < 4; s++) begin
            m_valid[s] = 4'b0000;
            m_plru[s]  = 3'b000;
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.data_wr_en) begin
                if (data_q.size() == 0) begin
                    check("data_unexpected", 1, 0);
                end else begin
                    dexp = data_q.pop_front();
                    check("data_wr", {bus.data_wr_index, bus.data_wr_way, bus.data_wr_beat, bus.data_wr_data}, dexp);
                end
            end
            if (bus.tag_wr_en) begin
                if (tag_q.size() == 0) begin
                    check("tag_unexpected", 1, 0);
                end else begin
                    texp = tag_q.pop_front();
                    check("tag_wr", {bus.tag_wr_index, bus.tag_wr_way, bus.tag_wr_tag}, texp);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.lookup_valid  = 1'b0;
        bus.lookup_index  = '0;
        bus.lookup_tag    = '0;
        bus.hit_raw       = '0;
        bus.flush         = 1'b0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_clear();
    endtask

    task automatic check_quiet(input string tag);
        @(negedge clk);
        check({tag, "_hit_q"}, bus.hit_q, 0);
        check({tag, "_stall"}, bus.miss_stall, 0);
        check({tag, "_req_valid"}, bus.mem_req_valid, 0);
        check({tag, "_req_addr"}, bus.mem_req_addr, 0);
        check({tag, "_data_wr"}, bus.data_wr_en, 0);
        check({tag, "_tag_wr"}, bus.tag_wr_en, 0);
        check({tag, "_tag_way"}, bus.tag_wr_way, 0);
        check({tag, "_fill_done"}, bus.fill_done, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic lookup_hit(input logic [1:0] idx, input logic [3:0] raw);
        bus.lookup_valid = 1'b1;
        bus.lookup_index = idx;
        bus.lookup_tag   = 8'hEE;
        bus.hit_raw      = raw;
        @(negedge clk);
        check("hit_q", bus.hit_q, raw & m_valid[idx]);
        check("hit_stall", bus.miss_stall, 0);
        @(posedge clk);
        #1 bus.lookup_valid = 1'b0;
        bus.hit_raw = '0;
        m_touch(idx, lowest(raw & m_valid[idx]));
    endtask

    task automatic miss_fill(input logic [1:0] idx, input logic [7:0] tag, input logic [3:0] raw,
                             input int req_wait, input int gap, input int nbeats, input logic flush_fill);
        logic [1:0]  w;
        logic [31:0] d;
        w = m_victim(idx);
        bus.lookup_valid = 1'b1;
        bus.lookup_index = idx;
        bus.lookup_tag   = tag;
        bus.hit_raw      = raw;
        @(negedge clk);
        check("miss_hit_q", bus.hit_q, raw & m_valid[idx]);
        check("miss_stall", bus.miss_stall, 1);
        @(posedge clk);
        #1 bus.lookup_valid = 1'b0;
        bus.hit_raw = '0;
        m_valid[idx][w] = 1'b0;
        for (int i = 0; i < req_wait; i++) begin
            bus.mem_rsp_valid = i[0];
            bus.mem_rsp_data  = $urandom;
            @(negedge clk);
            check("req_valid", bus.mem_req_valid, 1);
            check("req_addr", bus.mem_req_addr, {tag, idx});
            check("req_stall", bus.miss_stall, 1);
            @(posedge clk);
            #1;
        end
        bus.mem_rsp_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        check("req_valid_acc", bus.mem_req_valid, 1);
        check("req_addr_acc", bus.mem_req_addr, {tag, idx});
        @(posedge clk);
        #1 bus.mem_req_ready = 1'b0;
        bus.flush = flush_fill;
        @(negedge clk);
        check("req_drop", bus.mem_req_valid, 0);
        check("fill_stall", bus.miss_stall, 1);
        @(posedge clk);
        #1;
        for (int b = 0; b < nbeats; b++) begin
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            if (b == LINE_BEATS - 1) tag_q.push_back({idx, oh(w), tag});
            d = $urandom;
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = d;
            data_q.push_back({idx, oh(w), 2'(b), d});
            @(posedge clk);
            #1 bus.mem_rsp_valid = 1'b0;
        end
        bus.flush = 1'b0;
        if (nbeats < LINE_BEATS) begin
            rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            m_clear();
            check("abort_data_q", data_q.size(), 0);
            @(negedge clk);
            check("abort_stall", bus.miss_stall, 0);
            check("abort_tag_wr", bus.tag_wr_en, 0);
            check("abort_req", bus.mem_req_valid, 0);
            @(posedge clk);
            #1;
            return;
        end
        @(negedge clk);
        check("fill_done", bus.fill_done, 1);
        check("tagw_stall", bus.miss_stall, 1);
        @(posedge clk);
        #1;
        m_valid[idx][w] = 1'b1;
        m_touch(idx, w);
        @(negedge clk);
        check("done_pulse", bus.fill_done, 0);
        check("idle_stall", bus.miss_stall, 0);
        check("tag_q_empty", tag_q.size(), 0);
        check("data_q_empty", data_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();
        check_quiet("reset");

        // first miss into an empty cache, ready on second REQ cycle
        miss_fill(2'd1, 8'h5A, 4'b0000, 1, 0, 4, 1'b0);
        lookup_hit(2'd1, 4'b0001);

        // fill set 2 completely, touch way 1, next victim follows the tree
        do_reset();
        for (int k = 0; k < 4; k++) miss_fill(2'd2, 8'h10 + 8'(k), 4'b0000, 1, 0, 4, 1'b0);
        lookup_hit(2'd2, 4'b0010);
        miss_fill(2'd2, 8'h14, 4'b0000, 1, 0, 4, 1'b0);

        // raw hit on an invalid way is a miss; on a valid way it hits
        miss_fill(2'd3, 8'h30, 4'b0100, 1, 0, 4, 1'b0);
        lookup_hit(2'd2, 4'b0100);

        // long request back-pressure with stray response pulses
        miss_fill(2'd0, 8'h44, 4'b0000, 5, 0, 4, 1'b0);

        // gapped beats, reset after beat 2, then the same lookup again
        miss_fill(2'd0, 8'h55, 4'b0000, 1, 2, 3, 1'b0);
        check_quiet("post_abort");
        miss_fill(2'd0, 8'h55, 4'b0000, 1, 2, 4, 1'b0);

        // flush beats a same-cycle missing lookup
        bus.lookup_valid = 1'b1;
        bus.lookup_index = 2'd1;
        bus.lookup_tag   = 8'h77;
        bus.hit_raw      = 4'b0000;
        bus.flush        = 1'b1;
        @(negedge clk);
        check("flush_stall", bus.miss_stall, 0);
        @(posedge clk);
        #1 bus.lookup_valid = 1'b0;
        bus.flush = 1'b0;
        m_clear();
        @(negedge clk);
        check("flush_req", bus.mem_req_valid, 0);
        @(posedge clk);
        #1;
        miss_fill(2'd0, 8'h55, 4'b0001, 1, 0, 4, 1'b0);

        // flush held during a fill is ignored
        miss_fill(2'd1, 8'h66, 4'b0000, 1, 1, 4, 1'b1);
        lookup_hit(2'd1, 4'b0001);
        lookup_hit(2'd0, 4'b0001);

        check("end_data_q", data_q.size(), 0);
        check("end_tag_q", tag_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
